// File: rtl/f_final.sv
// -----------------------------------------------------------------------------
// f_final
//   Free-running two-digit BCD counter (00..99) with built-in seven-segment
//   decoding. It drives a two-digit common-cathode display directly.
//   A prescaler divides the clock so the count advances once every DIV
//   rising edges. Counting starts from 00 after reset is released.
//
// Parameters
//   DIV  clock cycles per count step (prescaler terminal count), legal >= 1
//
// Ports
//   clk  input   1   system clock; all state updates on the rising edge
//   rst  input   1   asynchronous active-low reset
//   s    output  14  segments, active-high {a,b,c,d,e,f,g} per digit:
//                    s[13:7] = tens digit, s[6:0] = ones digit
// -----------------------------------------------------------------------------
module f_final #(
  parameter int DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [13:0] s
);

  // The prescaler is at least one bit wide so DIV=1 still gives a legal vector.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LP_TERM = PW'(DIV - 1);

  logic [PW-1:0] r_pre;
  logic [3:0]    r_ones;
  logic [3:0]    r_tens;
  logic          w_step;

  // Step pulse on the same edge that the prescaler wraps back to zero.
  assign w_step = (r_pre == LP_TERM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the reset branch is in the sensitivity list
  // so the display clears the moment rst falls, without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre  <= '0;
      r_ones <= 4'd0;
      r_tens <= 4'd0;
    end else begin
      r_pre <= w_step ? '0 : r_pre + PW'(1);
      if (w_step) begin
        if (r_ones == 4'd9) begin
          r_ones <= 4'd0;
          // 99 wraps to 00 with no stall and no carry-out.
          r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end
    end
  end

  // Seven-segment decode, order {a,b,c,d,e,f,g}, a = MSB.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    // NOTE: the default arm assigns every input value, so this decode is pure
    // combinational logic; it also blanks the unreachable codes 10..15.
    case (digit)
      4'd0:    code = 7'b1111110;
      4'd1:    code = 7'b0110000;
      4'd2:    code = 7'b1101101;
      4'd3:    code = 7'b1111001;
      4'd4:    code = 7'b0110011;
      4'd5:    code = 7'b1011011;
      4'd6:    code = 7'b1011111;
      4'd7:    code = 7'b1110000;
      4'd8:    code = 7'b1111111;
      4'd9:    code = 7'b1111011;
      default: code = 7'b0000000;
    endcase
    return code;
  endfunction

  // No leading-zero blanking: the tens digit is always shown.
  always_comb begin
    s = {seg7(r_tens), seg7(r_ones)};
  end

endmodule

// File: tb/tb_f_final.sv
// -----------------------------------------------------------------------------
// tb_f_final
//   Directed bench for f_final. Two instances share one clock: one with DIV=1
//   and one with DIV=4, each with its own reset. Expected segment patterns
//   come from the digit table written out below.
// -----------------------------------------------------------------------------
module tb_f_final;

  logic        clk;
  logic        rst1;
  logic        rst4;
  logic [13:0] s1;
  logic [13:0] s4;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] seg_tbl [10];

  f_final #(.DIV(1)) u_dut1 (.clk(clk), .rst(rst1), .s(s1));
  f_final #(.DIV(4)) u_dut4 (.clk(clk), .rst(rst4), .s(s4));

  // Clock stays idle for the first 20 ns so the async reset is seen alone.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [13:0] got,
                       input logic [13:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %014b expected %014b", tag, got, exp);
  endtask

  function automatic logic [13:0] disp(input int value);
    return {seg_tbl[value / 10], seg_tbl[value % 10]};
  endfunction

  function automatic logic is_valid(input logic [6:0] code);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 10; k++) if (code === seg_tbl[k]) hit = 1'b1;
    return hit;
  endfunction

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    seg_tbl[0] = 7'b1111110; seg_tbl[1] = 7'b0110000;
    seg_tbl[2] = 7'b1101101; seg_tbl[3] = 7'b1111001;
    seg_tbl[4] = 7'b0110011; seg_tbl[5] = 7'b1011011;
    seg_tbl[6] = 7'b1011111; seg_tbl[7] = 7'b1110000;
    seg_tbl[8] = 7'b1111111; seg_tbl[9] = 7'b1111011;

    // Async reset with idle clock.
    rst1 = 1'b0;
    rst4 = 1'b0;
    #1;
    check("reset_idle_div1", s1, 14'b1111110_1111110);
    check("reset_idle_div4", s4, 14'b1111110_1111110);

    // Reset held while the clock runs.
    tick(3);
    check("reset_held_div1", s1, 14'b1111110_1111110);

    // DIV=1: release between edges, sweep all 100 values plus the wrap.
    rst1 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      check("sweep", s1, disp(i % 100));
      check("ones_valid", {7'd0, is_valid(s1[6:0])}, 14'd1);
      check("tens_valid", {7'd0, is_valid(s1[13:7])}, 14'd1);
      if (i == 9)   check("edge9_09",   s1, 14'b1111110_1111011);
      if (i == 10)  check("edge10_10",  s1, 14'b0110000_1111110);
      if (i == 99)  check("edge99_99",  s1, 14'b1111011_1111011);
      if (i == 100) check("edge100_00", s1, 14'b1111110_1111110);
    end
    // DIV=4 instance has been held in reset throughout.
    check("div4_still_reset", s4, 14'b1111110_1111110);

    // DIV=4: first step on the 4th edge, then every 4 edges.
    rst4 = 1'b1;
    tick(3);
    check("div4_edge3_00", s4, 14'b1111110_1111110);
    tick(1);
    check("div4_edge4_01", s4, 14'b1111110_0110000);
    tick(3);
    check("div4_edge7_01", s4, 14'b1111110_0110000);
    tick(1);
    check("div4_edge8_02", s4, 14'b1111110_1101101);

    // DIV=1 reset mid-count at 37.
    rst1 = 1'b0;
    #1;
    rst1 = 1'b1;
    tick(37);
    check("count_37", s1, 14'b1111001_1110000);
    #2;
    rst1 = 1'b0;
    #1;
    check("midreset_00", s1, 14'b1111110_1111110);
    tick(1);
    check("midreset_held", s1, 14'b1111110_1111110);
    rst1 = 1'b1;
    tick(1);
    check("after_release_01", s1, 14'b1111110_0110000);

    // DIV=4 reset mid-count restarts with a full prescaler delay.
    tick(2);
    rst4 = 1'b0;
    #1;
    check("div4_midreset_00", s4, 14'b1111110_1111110);
    rst4 = 1'b1;
    tick(3);
    check("div4_restart_edge3", s4, 14'b1111110_1111110);
    tick(1);
    check("div4_restart_edge4", s4, 14'b1111110_0110000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
